// File: rtl/qspi_pkg.sv
// Shared types and helpers for the QSPI receive deserialiser.
package qspi_pkg;

    // Lane mode; the reserved encoding 2'b11 is folded into QSPI_QUAD when latched.
    typedef enum logic [1:0] {
        QSPI_SINGLE = 2'b00,
        QSPI_DUAL   = 2'b01,
        QSPI_QUAD   = 2'b10
    } qspi_mode_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'b00,
        RX_SHIFT = 2'b01,
        RX_HOLD  = 2'b10
    } rx_state_e;

    // Number of data bits carried per beat in a given mode.
    function automatic logic [2:0] lanes(input qspi_mode_e mode);
        case (mode)
            QSPI_SINGLE: return 3'd1;
            QSPI_DUAL:   return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/qspi_lane_mux.sv
// Selects the active beat bits (right-aligned) and beat width from the IO sample.
module qspi_lane_mux
    import qspi_pkg::*;
(
    input  logic [3:0] qsd_i,
    input  qspi_mode_e mode_i,
    output logic [3:0] beat_o,
    output logic [2:0] width_o
);

    // Single mode reads MISO on IO[1]; wider modes take the low lanes as-is.
    always_comb begin
        width_o = lanes(mode_i);
        case (mode_i)
            QSPI_SINGLE: beat_o = {3'b000, qsd_i[1]};
            QSPI_DUAL:   beat_o = {2'b00, qsd_i[1:0]};
            default:     beat_o = qsd_i;
        endcase
    end

endmodule

// File: rtl/qspi_rx_deser.sv
// QSPI receive deserialiser: single/dual/quad lanes, runtime byte length,
// MSB/LSB-first order, completed word held behind a valid/ready handshake.
// Optional byte reversal of the completed word when QSPI_RX_BSWAP_EN is defined.
module qspi_rx_deser
    import qspi_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = $clog2(DATA_W / 8) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic              lsb_first_i,
    input  logic [LEN_W-1:0]  len_i,
`ifdef QSPI_RX_BSWAP_EN
    input  logic              bswap_i,
`endif
    input  logic              valid_i,
    input  logic [3:0]        qsd_i,
    input  logic              data_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic              busy_o,
    output logic              overflow_o
);

    localparam int unsigned NBYTES = DATA_W / 8;
    // len*8 needs exactly three more bits than len itself
    localparam int unsigned CNT_W  = LEN_W + 3;

    rx_state_e         r_state;
    rx_state_e         w_state_next;
    qspi_mode_e        r_mode;
    logic              r_lsb;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_sr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
`ifdef QSPI_RX_BSWAP_EN
    logic              r_bswap;
`endif

    logic [LEN_W-1:0]  w_len_norm;
    logic [CNT_W-1:0]  w_beats;
    logic              w_load;
    logic              w_shift;
    logic              w_last;
    logic [3:0]        w_beat;
    logic [2:0]        w_width;
    logic [DATA_W-1:0] w_sr_next;
    logic [DATA_W-1:0] w_aligned;
    logic [DATA_W-1:0] w_word;
    logic [CNT_W-1:0]  w_pad;

    // A start in HOLD only takes effect together with the handshake.
    assign w_load  = start_i && ((r_state != RX_HOLD) || data_ready_i);
    // A beat arriving with start_i belongs to neither word and is dropped.
    assign w_shift = (r_state == RX_SHIFT) && valid_i && !start_i;
    assign w_last  = w_shift && (r_cnt == CNT_W'(1));

    qspi_lane_mux u_lane_mux (
        .qsd_i   (qsd_i),
        .mode_i  (r_mode),
        .beat_o  (w_beat),
        .width_o (w_width)
    );

    // Normalise the requested length and derive the beat count for the new word.
    always_comb begin
        w_len_norm = len_i;
        if ((len_i == '0) || (len_i > LEN_W'(NBYTES))) begin
            w_len_norm = LEN_W'(NBYTES);
        end
        case (mode_i)
            2'b00:   w_beats = {w_len_norm, 3'b000};
            2'b01:   w_beats = {1'b0, w_len_norm, 2'b00};
            default: w_beats = {2'b00, w_len_norm, 1'b0};
        endcase
    end

    // Next shift-register value: MSB-first appends at the bottom, LSB-first enters at the top.
    always_comb begin
        case (w_width)
            3'd1: w_sr_next = r_lsb ? {w_beat[0], r_sr[DATA_W-1:1]}
                                    : {r_sr[DATA_W-2:0], w_beat[0]};
            3'd2: w_sr_next = r_lsb ? {w_beat[1:0], r_sr[DATA_W-1:2]}
                                    : {r_sr[DATA_W-3:0], w_beat[1:0]};
            default: w_sr_next = r_lsb ? {w_beat, r_sr[DATA_W-1:4]}
                                       : {r_sr[DATA_W-5:0], w_beat};
        endcase
    end

    // Right-align the completed word and zero everything above len bytes.
    always_comb begin
        w_pad = CNT_W'(DATA_W) - {r_len, 3'b000};
        if (r_lsb) begin
            w_aligned = w_sr_next >> w_pad;
        end else begin
            w_aligned = w_sr_next & ({DATA_W{1'b1}} >> w_pad);
        end
    end

`ifdef QSPI_RX_BSWAP_EN
    // Reverse the len valid bytes; bytes above len stay zero.
    always_comb begin
        int v_len;
        v_len  = int'(r_len);
        w_word = w_aligned;
        if (r_bswap) begin
            for (int b = 0; b < int'(NBYTES); b++) begin
                w_word[8*b +: 8] = 8'h00;
                if (b < v_len) begin
                    w_word[8*b +: 8] = w_aligned[8*(v_len-1-b) +: 8];
                end
            end
        end
    end
`else
    assign w_word = w_aligned;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RX_IDLE: begin
                if (start_i) w_state_next = RX_SHIFT;
            end
            RX_SHIFT: begin
                if (start_i) begin
                    w_state_next = RX_SHIFT;
                end else if (w_last) begin
                    w_state_next = RX_HOLD;
                end
            end
            RX_HOLD: begin
                if (data_ready_i) w_state_next = start_i ? RX_SHIFT : RX_IDLE;
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    // Outputs decoded from state; overflow flags a beat that has nowhere to go.
    always_comb begin
        data_o       = r_data;
        busy_o       = (r_state != RX_IDLE);
        data_valid_o = (r_state == RX_HOLD);
        overflow_o   = (r_state == RX_HOLD) && valid_i;
    end

    // Datapath: latch config on start, shift accepted beats, capture the finished word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode  <= QSPI_SINGLE;
            r_lsb   <= 1'b0;
            r_len   <= '0;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
`ifdef QSPI_RX_BSWAP_EN
            r_bswap <= 1'b0;
`endif
        end else if (w_load) begin
            r_mode  <= (mode_i == 2'b11) ? QSPI_QUAD : qspi_mode_e'(mode_i);
            r_lsb   <= lsb_first_i;
            r_len   <= w_len_norm;
            r_sr    <= '0;
            r_cnt   <= w_beats;
`ifdef QSPI_RX_BSWAP_EN
            r_bswap <= bswap_i;
`endif
        end else if (w_shift) begin
            r_sr  <= w_sr_next;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) r_data <= w_word;
        end
    end

endmodule

// File: tb/tb_qspi_rx_deser.sv
// Directed self-checking bench for qspi_rx_deser (byte-swap case under QSPI_RX_BSWAP_EN).
`timescale 1ns/1ps
module tb_qspi_rx_deser;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic        lsb;
    logic [2:0]  len;
    logic        bswap;
    logic        valid;
    logic [3:0]  qsd;
    logic        ready;
    logic [31:0] data;
    logic        data_valid;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    qspi_rx_deser #(.DATA_W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .mode_i       (mode),
        .lsb_first_i  (lsb),
        .len_i        (len),
`ifdef QSPI_RX_BSWAP_EN
        .bswap_i      (bswap),
`endif
        .valid_i      (valid),
        .qsd_i        (qsd),
        .data_ready_i (ready),
        .data_o       (data),
        .data_valid_o (data_valid),
        .busy_o       (busy),
        .overflow_o   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; checks happen there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle, then scramble the config inputs to prove they were latched.
    task automatic start_word(input logic [1:0] m, input logic l, input logic [2:0] n);
        start = 1'b1; mode = m; lsb = l; len = n;
        step();
        start = 1'b0; mode = ~m; lsb = ~l; len = 3'd1;
    endtask

    // Send n beats; beat i is nib[31-4i -: 4] (the raw qsd_i value).
    task automatic send_beats(input logic [31:0] nib, input int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'b1;
            qsd   = nib[31-4*i -: 4];
            step();
        end
        valid = 1'b0;
        qsd   = 4'h0;
    endtask

    task automatic release_word();
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; mode = 0; lsb = 0; len = 0; bswap = 0;
        valid = 0; qsd = 0; ready = 0;
        repeat (2) step();
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", data, 32'h0); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_quad_msb();
        start_word(2'b10, 1'b0, 3'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL qmsb_busy: got %b expected 1", busy); end
        send_beats(32'h12345678, 7);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL qmsb_early_valid: got %b expected 0", data_valid); end
        send_beats(32'h80000000, 1);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL qmsb_valid: got %b expected 1", data_valid); end
        checks++; if (data !== 32'h12345678) begin errors++; $display("FAIL qmsb_data: got %h expected %h", data, 32'h12345678); end
        release_word();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL qmsb_idle: got busy %b expected 0", busy); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL qmsb_valid_drop: got %b expected 0", data_valid); end
    endtask

    task automatic test_quad_lsb();
        start_word(2'b10, 1'b1, 3'd4);
        send_beats(32'h12345678, 8);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL qlsb_valid: got %b expected 1", data_valid); end
        checks++; if (data !== 32'h87654321) begin errors++; $display("FAIL qlsb_data: got %h expected %h", data, 32'h87654321); end
    endtask

    // Enters in HOLD from test_quad_lsb: ready and start together start a dual word.
    task automatic test_back_to_back();
        ready = 1'b1;
        start_word(2'b01, 1'b0, 3'd2);
        ready = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid: got %b expected 0", data_valid); end
        send_beats(32'h32100123, 8);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL dual_valid: got %b expected 1", data_valid); end
        checks++; if (data !== 32'h0000E41B) begin errors++; $display("FAIL dual_data: got %h expected %h", data, 32'h0000E41B); end
        release_word();
    endtask

    task automatic test_single();
        start_word(2'b00, 1'b0, 3'd1);
        // IO[1] carries 1,0,1,0,0,1,0,1
        send_beats(32'h20200202, 8);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", data_valid); end
        checks++; if (data !== 32'h000000A5) begin errors++; $display("FAIL single_data: got %h expected %h", data, 32'h000000A5); end
        release_word();
    endtask

    task automatic test_overflow();
        start_word(2'b10, 1'b0, 3'd4);
        send_beats(32'h87654321, 8);
        for (int i = 0; i < 2; i++) begin
            valid = 1'b1; qsd = 4'hF;
            #1;
            checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse%0d: got %b expected 1", i, overflow); end
            step();
            checks++; if (data !== 32'h87654321) begin errors++; $display("FAIL ovf_data%0d: got %h expected %h", i, data, 32'h87654321); end
        end
        valid = 1'b0;
        #1;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %b expected 1", data_valid); end
        release_word();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_idle: got busy %b expected 0", busy); end
    endtask

    // Abort after 3 beats; restart (reserved mode = quad, LSB, len 0 = 4 bytes) drops same-cycle beat.
    task automatic test_abort_restart();
        start_word(2'b10, 1'b0, 3'd4);
        send_beats(32'h12300000, 3);
        valid = 1'b1; qsd = 4'hF;
        start_word(2'b11, 1'b1, 3'd0);
        valid = 1'b0;
        send_beats(32'h12345678, 7);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL abort_early_valid: got %b expected 0", data_valid); end
        send_beats(32'h80000000, 1);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL abort_valid: got %b expected 1", data_valid); end
        checks++; if (data !== 32'h87654321) begin errors++; $display("FAIL abort_data: got %h expected %h", data, 32'h87654321); end
        release_word();
    endtask

    // valid in IDLE is ignored; start with same-cycle valid drops that beat.
    task automatic test_idle_valid();
        valid = 1'b1; qsd = 4'hF;
        #1;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL idle_ovf: got %b expected 0", overflow); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        start_word(2'b10, 1'b0, 3'd1);
        valid = 1'b0;
        send_beats(32'hA0000000, 1);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL len1_early_valid: got %b expected 0", data_valid); end
        send_beats(32'h50000000, 1);
        checks++; if (data !== 32'h000000A5) begin errors++; $display("FAIL len1_data: got %h expected %h", data, 32'h000000A5); end
        release_word();
    endtask

    task automatic test_reset_mid();
        start_word(2'b10, 1'b0, 3'd4);
        send_beats(32'h12300000, 3);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected %h", data, 32'h0); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", data_valid); end
        step();
        rst_n = 1'b1;
        step();
        start_word(2'b10, 1'b0, 3'd4);
        send_beats(32'h12345678, 8);
        checks++; if (data !== 32'h12345678) begin errors++; $display("FAIL rstmid_rerun: got %h expected %h", data, 32'h12345678); end
        release_word();
    endtask

`ifdef QSPI_RX_BSWAP_EN
    task automatic test_bswap();
        bswap = 1'b1;
        start_word(2'b10, 1'b0, 3'd4);
        bswap = 1'b0;
        send_beats(32'h12345678, 8);
        checks++; if (data !== 32'h78563412) begin errors++; $display("FAIL bswap_data: got %h expected %h", data, 32'h78563412); end
        release_word();
    endtask
`endif

    initial begin
        test_reset();
        test_quad_msb();
        test_quad_lsb();
        test_back_to_back();
        test_single();
        test_overflow();
        test_abort_restart();
        test_idle_valid();
        test_reset_mid();
`ifdef QSPI_RX_BSWAP_EN
        test_bswap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
